// File: rtl/ddr5_phy_crc_pkg.sv
// Shared constants and the byte-wide CRC-8 update for the DDR5 write-path CRC.
// Polynomial x^8+x^2+x+1, MSB of the data byte enters first.
package ddr5_phy_crc_pkg;

   localparam int        CRC_LANE_W = 8;
   localparam logic [7:0] CRC8_POLY  = 8'h07;
   localparam logic [7:0] CRC8_INIT  = 8'h00;

   function automatic logic [7:0] crc8_byte_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc;
      for (int i = CRC_LANE_W - 1; i >= 0; i--) begin
         c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? CRC8_POLY : 8'h00);
      end
      return c;
   endfunction

endpackage

// File: rtl/ddr5_phy_crc8_lane.sv
// One CRC-8 engine for a single 8-bit lane; consumes one byte per enabled clock.
// start_i restarts the accumulation from the seed using the current byte.
module ddr5_phy_crc8_lane
   import ddr5_phy_crc_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  start_i,
   input  logic [CRC_LANE_W-1:0] data_i,
   output logic [CRC_LANE_W-1:0] crc_o
);

   logic [CRC_LANE_W-1:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (en_i) crc_d = crc8_byte_step(start_i ? CRC8_INIT : crc_q, data_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) crc_q <= CRC8_INIT;
      else       crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ddr5_phy_crc_gen.sv
// Write-path burst CRC generator: one CRC-8 per 8-bit lane, burst framed by crc_en_i.
// A burst starts on the first enabled clock after an idle one; valid rises once it ends.
module ddr5_phy_crc_gen
   import ddr5_phy_crc_pkg::*;
#(
   parameter int pDRAM_SIZE = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    crc_en_i,
   input  logic [2*pDRAM_SIZE-1:0] crc_in_data_i,
   output logic [2*pDRAM_SIZE-1:0] crc_code_o,
   output logic                    crc_valid_o
);

   localparam int NL = pDRAM_SIZE / 4;

   logic en_q;
   logic valid_q, valid_d;
   logic start;

   logic [NL-1:0][CRC_LANE_W-1:0] lane_data;
   logic [NL-1:0][CRC_LANE_W-1:0] lane_crc;

   assign start     = crc_en_i & ~en_q;
   assign lane_data = crc_in_data_i;

   for (genvar k = 0; k < NL; k++) begin : g_lane
      ddr5_phy_crc8_lane u_lane (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .en_i    (crc_en_i),
         .start_i (start),
         .data_i  (lane_data[k]),
         .crc_o   (lane_crc[k])
      );
   end

   // Set on the falling edge of the enable, cleared by any enabled beat.
   always_comb begin
      valid_d = valid_q;
      if (crc_en_i)   valid_d = 1'b0;
      else if (en_q)  valid_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         en_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         en_q    <= crc_en_i;
         valid_q <= valid_d;
      end
   end

   assign crc_code_o  = lane_crc;
   assign crc_valid_o = valid_q;

endmodule

// File: tb/tb_ddr5_phy_crc_gen.sv
// Directed bench for ddr5_phy_crc_gen: an x4 and an x8 instance on a shared clock and reset.
module tb_ddr5_phy_crc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en4, en8;
   logic [7:0]  d4;
   logic [15:0] d8;
   logic [7:0]  code4;
   logic [15:0] code8;
   logic        vld4, vld8;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ddr5_phy_crc_gen #(.pDRAM_SIZE(4)) u_x4 (
      .clk_i(clk), .rst_i(rst), .crc_en_i(en4), .crc_in_data_i(d4),
      .crc_code_o(code4), .crc_valid_o(vld4)
   );

   ddr5_phy_crc_gen #(.pDRAM_SIZE(8)) u_x8 (
      .clk_i(clk), .rst_i(rst), .crc_en_i(en8), .crc_in_data_i(d8),
      .crc_code_o(code8), .crc_valid_o(vld8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [7:0]  burst_a  [8] = '{8'hAB, 8'hCD, 8'hEF, 8'hAB, 8'hCD, 8'hEF, 8'h76, 8'h32};
   logic [7:0]  burst_b  [8] = '{8'h98, 8'h76, 8'h54, 8'h32, 8'h10, 8'h98, 8'h54, 8'h10};

   initial begin
      rst = 1'b1; en4 = 1'b0; en8 = 1'b0; d4 = '0; d8 = '0;
      tick(); tick();
      chk("rst_code4", {8'h00, code4}, 16'h0000);
      chk("rst_vld4",  {15'd0, vld4},  16'h0000);
      chk("rst_code8", code8,          16'h0000);
      chk("rst_vld8",  {15'd0, vld8},  16'h0000);
      rst = 1'b0;
      tick();

      // single byte AB
      en4 = 1'b1; d4 = 8'hAB;
      tick();
      chk("one_byte_code", {8'h00, code4}, 16'h0058);
      chk("one_byte_vld_busy", {15'd0, vld4}, 16'h0000);
      en4 = 1'b0;
      tick();
      chk("one_byte_code_end", {8'h00, code4}, 16'h0058);
      chk("one_byte_vld_end", {15'd0, vld4}, 16'h0001);

      // 8-word burst, x4 and x8 together; must start fresh, not carry on from 58
      for (int i = 0; i < 8; i++) begin
         en4 = 1'b1; d4 = burst_a[i];
         en8 = 1'b1; d8 = {burst_a[i], burst_b[i]};
         tick();
         if (i == 0) begin
            chk("burstA_first4", {8'h00, code4}, 16'h0058);
            chk("burstA_first8_l1", {8'h00, code8[15:8]}, 16'h0058);
         end
         chk("burstA_vld_busy", {14'd0, vld4, vld8}, 16'h0000);
      end
      chk("burstA_code4", {8'h00, code4}, 16'h0011);
      chk("burstA_code8", code8, 16'h1182);
      en4 = 1'b0; en8 = 1'b0;
      tick();
      chk("burstA_hold4", {8'h00, code4}, 16'h0011);
      chk("burstA_vld4",  {15'd0, vld4},  16'h0001);
      chk("burstA_hold8", code8, 16'h1182);
      chk("burstA_vld8",  {15'd0, vld8},  16'h0001);

      // second x4 burst after one idle clock, independent of the first
      for (int i = 0; i < 8; i++) begin
         en4 = 1'b1; d4 = burst_b[i];
         tick();
      end
      chk("burstB_code4", {8'h00, code4}, 16'h0082);
      chk("x8_idle_hold", code8, 16'h1182);
      chk("x8_idle_vld",  {15'd0, vld8}, 16'h0001);
      en4 = 1'b0;
      tick();
      chk("burstB_vld4", {15'd0, vld4}, 16'h0001);

      // all-zero burst
      for (int i = 0; i < 8; i++) begin
         en4 = 1'b1; d4 = 8'h00;
         tick();
      end
      chk("zero_code4", {8'h00, code4}, 16'h0000);
      en4 = 1'b0;
      tick();
      chk("zero_vld4", {15'd0, vld4}, 16'h0001);

      // reset at word 4 of burst A, then full replay straight after reset
      for (int i = 0; i < 3; i++) begin
         en4 = 1'b1; d4 = burst_a[i];
         tick();
      end
      rst = 1'b1; d4 = burst_a[3];
      tick();
      chk("midrst_code4", {8'h00, code4}, 16'h0000);
      chk("midrst_vld4",  {15'd0, vld4},  16'h0000);
      chk("midrst_code8", code8, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         en4 = 1'b1; d4 = burst_a[i];
         tick();
         if (i == 0) chk("replay_first4", {8'h00, code4}, 16'h0058);
         chk("replay_vld_busy", {15'd0, vld4}, 16'h0000);
      end
      chk("replay_code4", {8'h00, code4}, 16'h0011);
      en4 = 1'b0; d4 = 8'h5A;
      tick();
      chk("replay_vld4", {15'd0, vld4}, 16'h0001);

      // long idle with changing data: everything holds
      for (int i = 0; i < 20; i++) begin
         d4 = 8'($urandom); d8 = 16'($urandom);
         tick();
      end
      chk("idle_code4", {8'h00, code4}, 16'h0011);
      chk("idle_vld4",  {15'd0, vld4},  16'h0001);
      chk("idle_code8", code8, 16'h0000);
      chk("idle_vld8",  {15'd0, vld8},  16'h0000);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ddr5_phy_crc_gen.md
Name: ddr5_phy_crc_gen

Overview:
Write-path CRC generator for the DDR5 PHY. It accumulates one BL16 burst (8 clocks, 2 UI per clock) of DQ data into one CRC-8 per 8-bit lane. The result is presented on a registered code output that is appended to the burst by the downstream serializer. There is one independent CRC-8 engine per 8-bit lane: one lane for x4 devices, two lanes for x8 devices.

Parameters:
pDRAM_SIZE, 4, device DQ width (legal values 4, 8, 16). Data and code width is 2*pDRAM_SIZE. Lane count NL = pDRAM_SIZE/4.

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
crc_en_i  input  1  qualifies crc_in_data_i as a valid burst word for this cycle.
crc_in_data_i  input  2*pDRAM_SIZE  burst word; lane k = bits [8k+7:8k].
crc_code_o  output  2*pDRAM_SIZE  registered CRC; lane k CRC = bits [8k+7:8k].
crc_valid_o  output  1  high while crc_code_o holds the CRC of a completed burst.

Behaviour:
- Clocking and reset
  - One clock, one synchronous active-high reset.
  - Reset sampled high at a rising edge clears:
    - every lane CRC to 8'h00;
    - crc_valid_o to 0;
    - the internal en_q register (previous crc_en_i) to 0.
  - Reset has priority over all other activity.
- CRC per lane
  - Polynomial x^8+x^2+x+1 (8'h07), seed 8'h00, no input or output reflection, no final XOR.
  - Each lane consumes its byte per enabled clock, MSB first (bit 7 is the first bit in time).
  - One byte-step equals 8 serial shifts. Each shift: crc = {crc[6:0],1'b0} ^ (crc[7]^d ? 8'h07 : 8'h00).
  - The update is combinational within one cycle, giving one lane-byte per clock.
- Burst accumulation
  - Start of burst: a rising edge where crc_en_i=1 and en_q=0. Each lane computes next = step(8'h00, byte); the previous result is discarded.
  - Continuing burst: crc_en_i=1 and en_q=1. Each lane computes next = step(crc, byte).
  - crc_en_i=0: all lane CRCs hold their value.
  - There is no internal beat counter. The burst length is whatever crc_en_i spans; the nominal length is 8 clocks.
- Latency
  - crc_code_o reflects all data sampled up to and including edge n, visible immediately after edge n.
  - The final CRC is valid immediately after the edge that samples the 8th word.
- Valid flag
  - crc_valid_o is set at an edge where crc_en_i=0 and en_q=1, i.e. the burst has ended.
  - It is cleared at any edge where crc_en_i=1.
  - Otherwise it holds.
- Boundary conditions
  - Back-to-back bursts separated by at least one idle clock: each burst is independent.
  - Enable held high continuously: all data is treated as one burst.
  - Reset mid-burst: CRC returns to 0 and en_q returns to 0, so the next enabled cycle starts a fresh burst.

Decomposition:
- Shared package ddr5_phy_crc_pkg:
  - CRC8_POLY = 8'h07, CRC8_INIT = 8'h00, CRC_LANE_W = 8;
  - function crc8_byte_step(crc, data) implementing the 8-shift update.
- Sub-module ddr5_phy_crc8_lane: one 8-bit register plus the update logic, with inputs start and en.
  - Top generates NL instances.
  - Top owns en_q and crc_valid_o.

Test Plan:
- x4, reset then one enabled byte AB, then enable low -> crc_code_o=8'h58, crc_valid_o=1.
- x4, burst AB CD EF AB CD EF 76 32 (one word per clock) -> 8'h11 after 8th edge; holds with enable low.
- x4, burst 98 76 54 32 10 98 54 10 issued after one idle clock following the previous burst -> 8'h82 (no carry-over from 8'h11).
- x8, burst AB98 CD76 EF54 AB32 CD10 EF98 7654 3210 -> 16'h1182 (lane1=11, lane0=82).
- x4, all-zero 8-word burst -> 8'h00. Reset asserted at word 4 of the AB.. burst, then the full burst replayed -> 8'h11; crc_valid_o low during the burst and high after.
- x4, idle for many clocks after a burst -> crc_code_o and crc_valid_o unchanged.
